slow_io_polarity: RTL and testbench

Parametrised, time-multiplexed polarity and offset corrector for the slow ADC/DAC channel banks. It compensates the inverting slow-path amplifiers with a per-channel programmable inversion, where inversion is x -> -(x+1), i.e. the bitwise complement, so the most negative code maps to the most positive. It then adds a per-channel signed offset with saturation. It sits between the slow converter interfaces and the servo logic, one instance per converter bank, and replaces the fixed-width, always-invert stage.

---
 rtl/slow_io_polarity.sv | 149 ++++++++++++++
 tb/tb_slow_io_polarity.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_io_polarity.sv
// Time-multiplexed per-channel polarity inversion and saturating offset
// for a bank of slow converter channels, one channel per clock.
module slow_io_polarity #(
  parameter int             N           = 16,
  parameter int             W           = 16,
  parameter logic [N-1:0]   INV_DEFAULT = {N{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_stb,
  input  logic [N*W-1:0]       in_data,
  output logic                 out_stb,
  output logic [N*W-1:0]       out_data,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 ovr_clr,
  input  logic                 cfg_we,
  input  logic [$clog2(N)-1:0] cfg_addr,
  input  logic                 cfg_inv,
  input  logic [W-1:0]         cfg_off
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [AW:0]   NCH  = (AW+1)'(N);
  localparam logic [W-1:0]  SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e state_q, state_d;
  logic [AW-1:0] ch_q, ch_d;

  logic [N-1:0][W-1:0] frame_q, frame_d;
  logic [N-1:0][W-1:0] stage_q, stage_d;
  logic [N-1:0][W-1:0] out_q, out_d;
  logic                out_stb_q, out_stb_d;
  logic                overrun_q, overrun_d;

  logic [N-1:0]        sh_inv_q, sh_inv_d;
  logic [N-1:0][W-1:0] sh_off_q, sh_off_d;
  logic [N-1:0]        act_inv_q, act_inv_d;
  logic [N-1:0][W-1:0] act_off_q, act_off_d;

  logic [W-1:0] x_cur;
  logic [W-1:0] v_cur;
  logic [W-1:0] off_cur;
  logic [W:0]   sum;
  logic [W-1:0] res;
  logic         cfg_hit;

  // Single shared datapath; ch_q selects the channel for this cycle.
  always_comb begin
    x_cur   = frame_q[ch_q];
    off_cur = act_off_q[ch_q];
    v_cur   = act_inv_q[ch_q] ? ~x_cur : x_cur;
    sum     = {v_cur[W-1], v_cur} + {off_cur[W-1], off_cur};
    res     = sum[W-1:0];
    if (sum[W] != sum[W-1]) begin
      res = sum[W] ? SMIN : SMAX;
    end
  end

  always_comb begin
    cfg_hit  = cfg_we && ({1'b0, cfg_addr} < NCH);
    sh_inv_d = sh_inv_q;
    sh_off_d = sh_off_q;
    if (cfg_hit) begin
      sh_inv_d[cfg_addr] = cfg_inv;
      sh_off_d[cfg_addr] = cfg_off;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    frame_d   = frame_q;
    stage_d   = stage_q;
    out_d     = out_q;
    out_stb_d = 1'b0;
    act_inv_d = act_inv_q;
    act_off_d = act_off_q;
    unique case (state_q)
      IDLE: begin
        if (in_stb) begin
          frame_d   = in_data;
          act_inv_d = sh_inv_q;
          act_off_d = sh_off_q;
          ch_d      = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        stage_d[ch_q] = res;
        if (ch_q == LAST) begin
          // Last result bypasses staging so the frame publishes this edge.
          out_d       = stage_q;
          out_d[LAST] = res;
          out_stb_d   = 1'b1;
          ch_d        = '0;
          state_d     = IDLE;
        end else begin
          ch_d = ch_q + AW'(1);
        end
      end
    endcase
  end

  always_comb begin
    overrun_d = (in_stb && (state_q == RUN)) || (overrun_q && !ovr_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      frame_q   <= '0;
      stage_q   <= '0;
      out_q     <= '0;
      out_stb_q <= 1'b0;
      overrun_q <= 1'b0;
      sh_inv_q  <= INV_DEFAULT;
      sh_off_q  <= '0;
      act_inv_q <= INV_DEFAULT;
      act_off_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      frame_q   <= frame_d;
      stage_q   <= stage_d;
      out_q     <= out_d;
      out_stb_q <= out_stb_d;
      overrun_q <= overrun_d;
      sh_inv_q  <= sh_inv_d;
      sh_off_q  <= sh_off_d;
      act_inv_q <= act_inv_d;
      act_off_q <= act_off_d;
    end
  end

  assign out_data = out_q;
  assign out_stb  = out_stb_q;
  assign busy     = (state_q == RUN);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_slow_io_polarity.sv
// Randomised bench for slow_io_polarity against a behavioural
// frame-level model of inversion, offset and saturation.
module tb_slow_io_polarity;

  localparam int N  = 16;
  localparam int W  = 16;
  localparam int AW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_stb;
  logic [N*W-1:0] in_data;
  logic           out_stb;
  logic [N*W-1:0] out_data;
  logic           busy;
  logic           overrun;
  logic           ovr_clr;
  logic           cfg_we;
  logic [AW-1:0]  cfg_addr;
  logic           cfg_inv;
  logic [W-1:0]   cfg_off;

  int tests = 0;
  int fails = 0;

  bit           m_sh_inv[N];
  logic [W-1:0] m_sh_off[N];
  bit           m_act_inv[N];
  logic [W-1:0] m_act_off[N];

  slow_io_polarity #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_stb(in_stb), .in_data(in_data),
    .out_stb(out_stb), .out_data(out_data),
    .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_inv(cfg_inv), .cfg_off(cfg_off)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ref_chan(input logic [W-1:0] x,
                                            input bit inv,
                                            input logic [W-1:0] off);
    longint xs, os, s, maxv, minv;
    logic [63:0] r;
    xs   = longint'($signed(x));
    os   = longint'($signed(off));
    maxv = (longint'(1) << (W - 1)) - 1;
    minv = -maxv - 1;
    s    = (inv ? (-xs - 1) : xs) + os;
    if (s > maxv) s = maxv;
    if (s < minv) s = minv;
    r = s;
    return r[W-1:0];
  endfunction

  function automatic logic [N*W-1:0] exp_frame(input logic [N*W-1:0] d);
    logic [N*W-1:0] e;
    for (int k = 0; k < N; k++)
      e[k*W +: W] = ref_chan(d[k*W +: W], m_act_inv[k], m_act_off[k]);
    return e;
  endfunction

  function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) d[k*W +: W] = v;
    return d;
  endfunction

  function automatic logic [W-1:0] rnd_sample();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = {1'b1, {(W-1){1'b0}}};
      1: v = {1'b0, {(W-1){1'b1}}};
      2: v = '0;
      3: v = '1;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  function automatic logic [N*W-1:0] rnd_frame();
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) d[k*W +: W] = rnd_sample();
    return d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_sh_inv[k]  = 1'b1;
      m_sh_off[k]  = '0;
      m_act_inv[k] = 1'b1;
      m_act_off[k] = '0;
    end
  endtask

  // Drives a strobe in the current cycle; the caller advances time.
  task automatic strobe(input logic [N*W-1:0] d, output logic [N*W-1:0] e);
    in_stb  = 1'b1;
    in_data = d;
    m_act_inv = m_sh_inv;
    m_act_off = m_sh_off;
    e = exp_frame(d);
  endtask

  task automatic cfg_write(input int a, input bit inv, input logic [W-1:0] off);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_inv  = inv;
    cfg_off  = off;
    tick();
    cfg_we = 1'b0;
    m_sh_inv[a] = inv;
    m_sh_off[a] = off;
  endtask

  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (out_stb !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    if (out_stb !== 1'b1) lat = -1;
  endtask

  task automatic do_frame(input logic [N*W-1:0] d,
                          output logic [N*W-1:0] e, output int lat);
    strobe(d, e);
    tick();
    in_stb = 1'b0;
    wait_out(1, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_stb = 0; in_data = '0; ovr_clr = 0;
    cfg_we = 0; cfg_addr = '0; cfg_inv = 0; cfg_off = '0;
    model_reset();
    tick(); tick();
    tests++;
    if ({out_stb, busy, overrun} !== 3'b000 || out_data !== '0) begin
      fails++;
      $display("FAIL reset: stb/busy/ovr=%b data=%h req 000/0",
               {out_stb, busy, overrun}, out_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_defaults();
    logic [N*W-1:0] e, held;
    logic [W-1:0]   req[3];
    logic [W-1:0]   inp[3];
    int lat;
    inp[0] = 16'h8000; req[0] = 16'h7fff;
    inp[1] = 16'h0000; req[1] = 16'hffff;
    inp[2] = 16'd1234; req[2] = 16'hfb2d;
    for (int i = 0; i < 3; i++) begin
      do_frame(fill(inp[i]), e, lat);
      tests++;
      if (lat !== 17) begin
        fails++;
        $display("FAIL default_lat[%0d]: got %0d req 17", i, lat);
      end
      tests++;
      if (out_data !== fill(req[i]) || busy !== 1'b0) begin
        fails++;
        $display("FAIL default_data[%0d]: got %h busy=%b req %h", i,
                 out_data, busy, fill(req[i]));
      end
      held = out_data;
      tick(); tick();
      tests++;
      if (out_stb !== 1'b0 || out_data !== held) begin
        fails++;
        $display("FAIL default_hold[%0d]: stb=%b data=%h req 0/%h", i,
                 out_stb, out_data, held);
      end
    end
  endtask

  task automatic test_cfg_pos();
    logic [N*W-1:0] d, e;
    int lat;
    cfg_write(3, 1'b0, 16'd100);
    tick();
    d = rnd_frame(); d[3*W +: W] = 16'd5;
    do_frame(d, e, lat);
    tests++;
    if (lat !== 17 || out_data[3*W +: W] !== 16'd105 || out_data !== e) begin
      fails++;
      $display("FAIL cfg_pos: lat=%0d ch3=%0d data=%h req 17/105/%h", lat,
               $signed(out_data[3*W +: W]), out_data, e);
    end
    tick();
    d = rnd_frame(); d[3*W +: W] = 16'd32700;
    do_frame(d, e, lat);
    tests++;
    if (out_data[3*W +: W] !== 16'h7fff || out_data !== e) begin
      fails++;
      $display("FAIL cfg_pos_sat: ch3=%h data=%h req 7fff/%h",
               out_data[3*W +: W], out_data, e);
    end
  endtask

  task automatic test_cfg_neg();
    logic [N*W-1:0] d, e;
    int lat;
    cfg_write(7, 1'b1, -16'sd10);
    d = rnd_frame(); d[7*W +: W] = 16'h7fff;
    do_frame(d, e, lat);
    tests++;
    if (out_data[7*W +: W] !== 16'h8000 || out_data !== e) begin
      fails++;
      $display("FAIL cfg_neg_sat: ch7=%h data=%h req 8000/%h",
               out_data[7*W +: W], out_data, e);
    end
    tick();
    d = rnd_frame(); d[7*W +: W] = 16'h0000;
    do_frame(d, e, lat);
    tests++;
    if (out_data[7*W +: W] !== 16'hfff5 || out_data !== e) begin
      fails++;
      $display("FAIL cfg_neg: ch7=%h data=%h req fff5/%h",
               out_data[7*W +: W], out_data, e);
    end
  endtask

  task automatic test_overrun();
    logic [N*W-1:0] e, e2;
    int lat;
    strobe(rnd_frame(), e);
    tick();
    in_stb = 0;
    repeat (4) tick();
    in_stb = 1; in_data = ~in_data;
    tick();
    in_stb = 0;
    tests++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: ovr=%b busy=%b req 1/1", overrun, busy);
    end
    wait_out(6, lat);
    tests++;
    if (lat !== 17 || out_data !== e) begin
      fails++;
      $display("FAIL overrun_frame: lat=%0d data=%h req 17/%h", lat, out_data, e);
    end
    tick();
    tests++;
    if (out_stb !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_drop: stb=%b busy=%b ovr=%b req 0/0/1",
               out_stb, busy, overrun);
    end
    ovr_clr = 1;
    tick();
    ovr_clr = 0;
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clr: got %b req 0", overrun);
    end
    strobe(rnd_frame(), e2);
    tick();
    in_stb = 1; ovr_clr = 1;
    tick();
    in_stb = 0; ovr_clr = 0;
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set_wins: got %b req 1", overrun);
    end
    wait_out(2, lat);
    tests++;
    if (lat !== 17 || out_data !== e2) begin
      fails++;
      $display("FAIL overrun_frame2: lat=%0d data=%h req 17/%h", lat, out_data, e2);
    end
    ovr_clr = 1;
    tick();
    ovr_clr = 0;
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] e0, e1, e2;
    logic [W-1:0] d0;
    int lat;
    d0 = 16'h0123;
    strobe(fill(d0), e0);
    tick();
    in_stb = 0;
    wait_out(1, lat);
    tests++;
    if (lat !== 17 || out_data !== e0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_f0: lat=%0d busy=%b data=%h req 17/0/%h",
               lat, busy, out_data, e0);
    end
    strobe(fill(d0), e1);
    cfg_we = 1; cfg_addr = '0; cfg_inv = 0; cfg_off = '0;
    tick();
    in_stb = 0; cfg_we = 0;
    m_sh_inv[0] = 1'b0; m_sh_off[0] = '0;
    wait_out(1, lat);
    tests++;
    if (lat !== 17 || out_data !== e1 || out_data[W-1:0] !== 16'hfedc) begin
      fails++;
      $display("FAIL b2b_f1: lat=%0d data=%h req 17/%h", lat, out_data, e1);
    end
    strobe(fill(d0), e2);
    tick();
    in_stb = 0;
    wait_out(1, lat);
    tests++;
    if (lat !== 17 || out_data !== e2 || out_data[W-1:0] !== 16'h0123) begin
      fails++;
      $display("FAIL b2b_f2: lat=%0d data=%h req 17/%h", lat, out_data, e2);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [N*W-1:0] e;
    int lat, seen;
    strobe(rnd_frame(), e);
    tick();
    in_stb = 0;
    repeat (7) tick();
    rst_n = 0;
    #1;
    tests++;
    if (out_data !== '0 || busy !== 1'b0 || out_stb !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: data=%h busy=%b stb=%b req 0/0/0",
               out_data, busy, out_stb);
    end
    model_reset();
    seen = 0;
    repeat (3) begin tick(); if (out_stb === 1'b1) seen++; end
    rst_n = 1;
    repeat (20) begin tick(); if (out_stb === 1'b1) seen++; end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL reset_mid_nostb: got %0d strobes req 0", seen);
    end
    do_frame(rnd_frame(), e, lat);
    tests++;
    if (lat !== 17 || out_data !== e) begin
      fails++;
      $display("FAIL reset_mid_next: lat=%0d data=%h req 17/%h", lat, out_data, e);
    end
    tick();
  endtask

  task automatic test_random();
    logic [N*W-1:0] e;
    int lat;
    for (int f = 0; f < 12; f++) begin
      repeat ($urandom_range(0, 3))
        cfg_write($urandom_range(0, N - 1), 1'($urandom), rnd_sample());
      strobe(rnd_frame(), e);
      tick();
      in_stb = 0;
      cfg_write($urandom_range(0, N - 1), 1'($urandom), rnd_sample());
      wait_out(2, lat);
      tests++;
      if (lat !== 17 || out_data !== e) begin
        fails++;
        $display("FAIL random[%0d]: lat=%0d data=%h req 17/%h", f, lat, out_data, e);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_cfg_pos();
    test_cfg_neg();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
